pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter and run-control stage feeding picoMIPS program memory.
//  Consumes the decoder's PCincr/PCrelbranch and a sign-extended branch offset.
//  Produces the instruction address PCout and an execute-enable that gates
//  register-file writes.
//  Adds start/halt/single-step control so the core idles after reset and halts
//  on a branch-to-self.
// PARAMETERS
//  Psize  6   PC / program-address width in bits (program memory depth 2**Psize)
//  Csize  16  width of the retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  n_reset      in   1      asynchronous active-low reset
//  start        in   1      synchronous one-cycle request: begin execution at PC=0
//  step_mode    in   1      1 = execute one instruction per rising edge of step
//  step         in   1      single-step request, level input, rising-edge detected
//  PCincr       in   1      from decoder: advance PC by 1
//  PCrelbranch  in   1      from decoder: take relative branch
//  Branchaddr   in   Psize  signed two's-complement branch offset
//  PCout        out  Psize  current instruction address
//  exec_en      out  1      instruction at PCout executes this cycle (ANDed with decoder w)
//  running      out  1      state == RUN
//  halted       out  1      state == HALT
//  icount       out  Csize  retired-instruction count, saturating
// BEHAVIOUR
//  Reset (n_reset low, async): state=IDLE, PCout=0, step_q=0, icount=0.
//   exec_en, running and halted are all 0 during reset.
//  States: IDLE, RUN, HALT (registered). running/halted decode state combinationally.
//  step_rise = step & ~step_q; step_q <= step every cycle.
//  advance = (state==RUN) & (~step_mode | step_rise).
//   exec_en = advance (combinational).
//  IDLE: PC held at 0. start -> RUN next cycle; no instruction executes in the start cycle.
//  RUN, advance=1, on the clock edge:
//   - PCrelbranch=1, Branchaddr==0 -> HALT; PC unchanged; icount+1.
//   - PCrelbranch=1, otherwise -> PC <= PC + Branchaddr (mod 2**Psize); icount+1.
//   - PCincr=1 only -> PC <= PC + 1 (mod 2**Psize); icount+1.
//   - neither -> PC held; icount+1.
//  RUN, advance=0: PC, state and icount held.
//   The step-mode wait is an ordinary RUN cycle with exec_en=0.
//  Priority: PCrelbranch overrides PCincr when both are 1.
//  Wrap: PC=2**Psize-1 with PCincr -> 0. Negative offset below 0 wraps modulo 2**Psize.
//  icount saturates at 2**Csize-1; it is never cleared except by reset or start.
//  start in RUN: ignored.
//  start in HALT: -> RUN; PC <= 0; icount <= 0.
//  start in IDLE: also clears icount.
//  step_mode may change any cycle and takes effect on the same cycle's advance.
//  A step held high executes exactly one instruction.
//  Latency: PCout changes one clock after the advancing cycle.
//   Program memory and decoder are combinational, single-cycle.
//  Reset asserted mid-RUN or mid-HALT: immediate return to IDLE with PC=0.
//  No X-propagation: every register has a reset value; no latches.
// TESTING
//  1 Reset, then start pulse, step_mode=0, PCincr=1 for 5 cycles -> PCout 0,1,2,3,4,5;
//    exec_en=1 from the cycle after start; icount=5.
//  2 At PC=10, PCrelbranch=1, PCincr=1, Branchaddr=6'h3D (-3) -> PCout=7 next cycle;
//    the branch wins over the increment.
//  3 Psize=6, PC=63, PCincr=1 -> PCout=0.
//    PC=2, Branchaddr=6'h3C (-4) -> PCout=62.
//  4 PCrelbranch=1, Branchaddr=0 in RUN -> halted=1 next cycle; PC frozen; exec_en=0.
//    Later start -> running=1, PCout=0, icount=0.
//  5 step_mode=1, step held high 4 cycles, low 2, then high 1 -> exactly 2 PC increments;
//    exec_en is high on only those 2 cycles.
//  6 Drive n_reset low asynchronously mid-cycle in RUN at PC=20 -> PCout=0 and
//    running=0 immediately.
//    A start pulse during RUN is ignored, with no change to PC or icount.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus between the picoMIPS decoder/run controller and the PC sequencer.
// The master drives the controls; the slave returns the PC and run status.
interface pc_sequencer_if #(
  parameter int Psize = 6,
  parameter int Csize = 16
);
  logic             start;
  logic             step_mode;
  logic             step;
  logic             PCincr;
  logic             PCrelbranch;
  logic [Psize-1:0] Branchaddr;
  logic [Psize-1:0] PCout;
  logic             exec_en;
  logic             running;
  logic             halted;
  logic [Csize-1:0] icount;

  modport master (
    output start, step_mode, step, PCincr, PCrelbranch, Branchaddr,
    input  PCout, exec_en, running, halted, icount
  );

  modport slave (
    input  start, step_mode, step, PCincr, PCrelbranch, Branchaddr,
    output PCout, exec_en, running, halted, icount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and run control for picoMIPS: idles after reset, runs on start,
// supports single-step, halts on a branch-to-self and counts retired instructions.
module pc_sequencer #(
  parameter int Psize = 6,
  parameter int Csize = 16
) (
  input  logic           clk,
  input  logic           n_reset,
  pc_sequencer_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]       state;
  logic [Psize-1:0] pc;
  logic [Csize-1:0] icount;
  logic             step_q;
  logic             step_rise;
  logic             advance;

  assign step_rise = bus.step & ~step_q;
  assign advance   = (state == RUN) & (~bus.step_mode | step_rise);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      pc     <= '0;
      icount <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
      case (state)
        IDLE: begin
          pc <= '0;
          if (bus.start) begin
            state  <= RUN;
            icount <= '0;
          end
        end
        RUN: begin
          if (advance) begin
            icount <= (icount == {Csize{1'b1}}) ? icount : icount + 1'b1;
            // Relative branch beats increment; a zero offset is a branch-to-self.
            if (bus.PCrelbranch) begin
              if (bus.Branchaddr == '0) state <= HALT;
              else                      pc    <= pc + bus.Branchaddr;
            end else if (bus.PCincr) begin
              pc <= pc + 1'b1;
            end
          end
        end
        HALT: begin
          if (bus.start) begin
            state  <= RUN;
            pc     <= '0;
            icount <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.PCout   = pc;
  assign bus.exec_en = advance;
  assign bus.running = (state == RUN);
  assign bus.halted  = (state == HALT);
  assign bus.icount  = icount;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, random run against a reference
// model, async reset mid-run, and counter saturation on a narrow-counter instance.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.Psize(6), .Csize(16)) bus ();
  pc_sequencer_if #(.Psize(6), .Csize(3))  bus2 ();

  pc_sequencer #(.Psize(6), .Csize(16)) dut  (.clk(clk), .n_reset(n_reset), .bus(bus));
  pc_sequencer #(.Psize(6), .Csize(3))  dut2 (.clk(clk), .n_reset(n_reset), .bus(bus2));

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 idle, 1 running, 2 halted
  int m_mode, m_pc, m_cnt;
  bit m_sq;

  typedef struct {
    logic st, sm, sp, inc, rb;
    logic [5:0] ba;
    int pc;
    logic ex, run, hlt;
    int ic;
  } vec_t;

  vec_t vt[28];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cnt = 0; m_sq = 0;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  // Drive one cycle's inputs, compare pre-edge outputs with the model, then clock.
  task automatic tick(input logic st, sm, sp, inc, rb, input logic [5:0] ba,
                      output logic [24:0] obs);
    bit adv;
    logic [24:0] exp;
    bus.start = st; bus.step_mode = sm; bus.step = sp;
    bus.PCincr = inc; bus.PCrelbranch = rb; bus.Branchaddr = ba;
    #1;
    adv = (m_mode == 1) && (!sm || (sp && !m_sq));
    exp = {6'(m_pc), adv, m_mode == 1, m_mode == 2, 16'(m_cnt)};
    obs = {bus.PCout, bus.exec_en, bus.running, bus.halted, bus.icount};
    check("model", 32'(obs), 32'(exp));
    @(posedge clk);
    m_sq = sp;
    if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (adv) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (rb) begin
          if (ba == 0) m_mode = 2;
          else m_pc = (((m_pc + int'($signed(ba))) % 64) + 64) % 64;
        end else if (inc) begin
          m_pc = (m_pc + 1) % 64;
        end
      end
    end else if (st) begin
      m_mode = 1; m_pc = 0; m_cnt = 0;
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic st, sm, sp, inc, rb, logic [5:0] ba,
                              int pc, logic ex, run, hlt, int ic);
    vec_t v;
    v.st = st; v.sm = sm; v.sp = sp; v.inc = inc; v.rb = rb; v.ba = ba;
    v.pc = pc; v.ex = ex; v.run = run; v.hlt = hlt; v.ic = ic;
    return v;
  endfunction

  initial begin
    logic [24:0] obs;
    logic [24:0] want;
    bus.start = 0; bus.step_mode = 0; bus.step = 0;
    bus.PCincr = 0; bus.PCrelbranch = 0; bus.Branchaddr = '0;
    bus2.start = 0; bus2.step_mode = 0; bus2.step = 0;
    bus2.PCincr = 0; bus2.PCrelbranch = 0; bus2.Branchaddr = '0;

    //            st sm sp in rb ba      pc ex run hlt ic
    vt[0]  = mk(0, 0, 0, 0, 0, 6'h00,  0, 0, 0, 0,  0);
    vt[1]  = mk(1, 0, 0, 0, 0, 6'h00,  0, 0, 0, 0,  0);
    vt[2]  = mk(0, 0, 0, 1, 0, 6'h00,  0, 1, 1, 0,  0);
    vt[3]  = mk(0, 0, 0, 1, 0, 6'h00,  1, 1, 1, 0,  1);
    vt[4]  = mk(0, 0, 0, 1, 0, 6'h00,  2, 1, 1, 0,  2);
    vt[5]  = mk(0, 0, 0, 1, 0, 6'h00,  3, 1, 1, 0,  3);
    vt[6]  = mk(0, 0, 0, 1, 0, 6'h00,  4, 1, 1, 0,  4);
    vt[7]  = mk(0, 0, 0, 0, 0, 6'h00,  5, 1, 1, 0,  5);
    vt[8]  = mk(0, 0, 0, 0, 1, 6'h05,  5, 1, 1, 0,  6);
    vt[9]  = mk(0, 0, 0, 1, 1, 6'h3D, 10, 1, 1, 0,  7);
    vt[10] = mk(0, 0, 0, 0, 1, 6'h38,  7, 1, 1, 0,  8);
    vt[11] = mk(0, 0, 0, 1, 0, 6'h00, 63, 1, 1, 0,  9);
    vt[12] = mk(0, 0, 0, 1, 0, 6'h00,  0, 1, 1, 0, 10);
    vt[13] = mk(0, 0, 0, 1, 0, 6'h00,  1, 1, 1, 0, 11);
    vt[14] = mk(0, 0, 0, 0, 1, 6'h3C,  2, 1, 1, 0, 12);
    vt[15] = mk(0, 0, 0, 0, 1, 6'h00, 62, 1, 1, 0, 13);
    vt[16] = mk(0, 0, 0, 1, 0, 6'h00, 62, 0, 0, 1, 14);
    vt[17] = mk(1, 0, 0, 0, 0, 6'h00, 62, 0, 0, 1, 14);
    vt[18] = mk(0, 1, 0, 1, 0, 6'h00,  0, 0, 1, 0,  0);
    vt[19] = mk(0, 1, 1, 1, 0, 6'h00,  0, 1, 1, 0,  0);
    vt[20] = mk(0, 1, 1, 1, 0, 6'h00,  1, 0, 1, 0,  1);
    vt[21] = mk(0, 1, 1, 1, 0, 6'h00,  1, 0, 1, 0,  1);
    vt[22] = mk(0, 1, 1, 1, 0, 6'h00,  1, 0, 1, 0,  1);
    vt[23] = mk(0, 1, 0, 1, 0, 6'h00,  1, 0, 1, 0,  1);
    vt[24] = mk(0, 1, 0, 1, 0, 6'h00,  1, 0, 1, 0,  1);
    vt[25] = mk(0, 1, 1, 1, 0, 6'h00,  1, 1, 1, 0,  1);
    vt[26] = mk(1, 1, 0, 1, 0, 6'h00,  2, 0, 1, 0,  2);
    vt[27] = mk(0, 1, 0, 1, 0, 6'h00,  2, 0, 1, 0,  2);

    #1;
    check("reset_outputs", 32'({bus.PCout, bus.exec_en, bus.running, bus.halted, bus.icount}), 32'd0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 28; i++) begin
      tick(vt[i].st, vt[i].sm, vt[i].sp, vt[i].inc, vt[i].rb, vt[i].ba, obs);
      want = {6'(vt[i].pc), vt[i].ex, vt[i].run, vt[i].hlt, 16'(vt[i].ic)};
      check($sformatf("vec%0d", i), 32'(obs), 32'(want));
    end

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic st, sm, sp, inc, rb;
      logic [5:0] ba;
      st  = ($urandom_range(0, 99) < 6);
      sm  = ($urandom_range(0, 99) < 30);
      sp  = $urandom_range(0, 1);
      inc = $urandom_range(0, 1);
      rb  = ($urandom_range(0, 99) < 30);
      ba  = ($urandom_range(0, 9) == 0) ? 6'h00 : 6'($urandom);
      tick(st, sm, sp, inc, rb, ba, obs);
    end

    // asynchronous reset mid-cycle while running at PC=20
    do_reset();
    tick(1, 0, 0, 0, 0, 6'h00, obs);
    tick(0, 0, 0, 0, 1, 6'd20, obs);
    tick(0, 1, 0, 0, 0, 6'h00, obs);
    check("pc_before_async_reset", 32'(obs[24:19]), 32'd20);
    #3;
    n_reset = 1'b0;
    #1;
    check("async_reset_pc", 32'(bus.PCout), 32'd0);
    check("async_reset_running", 32'(bus.running), 32'd0);
    check("async_reset_exec_en", 32'(bus.exec_en), 32'd0);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;

    // saturation on the 3-bit counter instance
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_icount_mid", 32'(bus2.icount), 32'd5);
    repeat (5) @(negedge clk);
    check("sat_icount_full", 32'(bus2.icount), 32'd7);
    check("sat_still_running", 32'(bus2.running), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
